// File: rtl/rv32_icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package rv32_icache_pkg;

  // Controller states: IDLE serves lookups, REFILL streams one line from memory.
  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_e;

  // Word-offset field width within a line.
  function automatic int calc_off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Line-index field width.
  function automatic int calc_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: what is left of the 30-bit word address after index and offset.
  function automatic int calc_tag_w(input int lines, input int line_words);
    return 30 - $clog2(lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/rv32_icache_store.sv
// Cache storage: valid bits in flops, tag and data arrays with combinational
// read ports. Tag/data have no reset; valid bits alone decide what is live.
module rv32_icache_store
  import rv32_icache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = calc_idx_w(LINES),
  parameter int OFF_W      = calc_off_w(LINE_WORDS),
  parameter int TAG_W      = calc_tag_w(LINES, LINE_WORDS)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  // lookup port
  input  logic [IDX_W-1:0] rd_index_i,
  input  logic [OFF_W-1:0] rd_offset_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [31:0]      rd_data_o,
  // refill word write
  input  logic             word_we_i,
  input  logic [IDX_W-1:0] wr_index_i,
  input  logic [OFF_W-1:0] wr_offset_i,
  input  logic [31:0]      wr_data_i,
  // line tag/valid write (uses wr_index_i)
  input  logic             line_we_i,
  input  logic             line_valid_i,
  input  logic [TAG_W-1:0] line_tag_i,
  // invalidate every line; wins over a line valid write
  input  logic             clear_all_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*LINE_WORDS];

  // Valid bits: reset and clear-all take priority over a line install.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
    end else if (clear_all_i) begin
      valid_q <= '0;
    end else if (line_we_i) begin
      valid_q[wr_index_i] <= line_valid_i;
    end
  end

  // Tag array write on line completion.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[wr_index_i] <= line_tag_i;
    end
  end

  // Data array write, one word per memory beat.
  always_ff @(posedge clk_i) begin
    if (word_we_i) begin
      data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[{rd_index_i, rd_offset_i}];

endmodule

// File: rtl/rv32_icache.sv
// Direct-mapped read-only instruction cache. Hits return in the request cycle;
// misses stream a full line from memory in order, then the held request hits.
//
// Handshake: the core holds instr_read_in with a stable address until
// instr_ready_out is seen high; a fetch completes in exactly the cycle where
// instr_ready_out=1. On the memory side mem_read_out/mem_address_out stay
// stable until a cycle with mem_ready_in=1 completes that beat.
module rv32_icache
  import rv32_icache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic        flush_in,
  output logic [31:0] mem_address_out,
  output logic        mem_read_out,
  input  logic [31:0] mem_read_value_in,
  input  logic        mem_ready_in
);

  localparam int OFF_W = calc_off_w(LINE_WORDS);
  localparam int IDX_W = calc_idx_w(LINES);
  localparam int TAG_W = calc_tag_w(LINES, LINE_WORDS);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_e           state_q;
  logic [OFF_W-1:0] beat_q;
  logic             flush_pending_q;
  logic [TAG_W-1:0] miss_tag_q;
  logic [IDX_W-1:0] miss_idx_q;
  logic             mem_read_q;
  logic [31:0]      mem_addr_q;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             miss;
  logic             beat_done;
  logic             last_beat;
  logic             flush_seen;
  logic             clear_all;
  logic [OFF_W-1:0] beat_nxt;
  logic             unused_addr_lsb;

  assign req_off = instr_address_in[OFF_W+1:2];
  assign req_idx = instr_address_in[IDX_W+OFF_W+1:OFF_W+2];
  assign req_tag = instr_address_in[31:IDX_W+OFF_W+2];
  assign unused_addr_lsb = ^instr_address_in[1:0];

  // Lookup, refill strobes and the combined invalidate request.
  always_comb begin
    hit        = (state_q == IDLE) && instr_read_in && rd_valid &&
                 (rd_tag == req_tag) && !flush_in;
    miss       = (state_q == IDLE) && instr_read_in && !hit && !flush_in;
    beat_done  = (state_q == REFILL) && mem_ready_in;
    last_beat  = beat_done && (beat_q == LAST_BEAT);
    flush_seen = flush_pending_q || flush_in;
    clear_all  = ((state_q == IDLE) && flush_in) || (last_beat && flush_seen);
    beat_nxt   = beat_q + OFF_W'(1);
  end

  rv32_icache_store #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_store (
    .clk_i        (clk),
    .reset_i      (reset),
    .rd_index_i   (req_idx),
    .rd_offset_i  (req_off),
    .rd_valid_o   (rd_valid),
    .rd_tag_o     (rd_tag),
    .rd_data_o    (rd_data),
    .word_we_i    (beat_done),
    .wr_index_i   (miss_idx_q),
    .wr_offset_i  (beat_q),
    .wr_data_i    (mem_read_value_in),
    .line_we_i    (last_beat),
    .line_valid_i (!flush_seen),
    .line_tag_i   (miss_tag_q),
    .clear_all_i  (clear_all)
  );

  // Controller FSM: latches the miss, counts beats, tracks a deferred flush
  // and registers the memory-side request outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      flush_pending_q <= 1'b0;
      miss_tag_q      <= '0;
      miss_idx_q      <= '0;
      mem_read_q      <= 1'b0;
      mem_addr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss) begin
            state_q         <= REFILL;
            miss_tag_q      <= req_tag;
            miss_idx_q      <= req_idx;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
            mem_read_q      <= 1'b1;
            mem_addr_q      <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (flush_in) begin
            flush_pending_q <= 1'b1;
          end
          if (mem_ready_in) begin
            beat_q     <= beat_nxt;
            mem_addr_q <= {miss_tag_q, miss_idx_q, beat_nxt, 2'b00};
            if (beat_q == LAST_BEAT) begin
              state_q         <= IDLE;
              mem_read_q      <= 1'b0;
              flush_pending_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready_out      = hit;
  assign instr_read_value_out = hit ? rd_data : 32'h0;
  assign mem_read_out         = mem_read_q;
  assign mem_address_out      = mem_addr_q;

endmodule

// File: tb/tb_rv32_icache.sv
// Bench for rv32_icache: directed scenarios plus a randomized run, all checked
// every cycle against a line-level model of the cache and a fixed memory image.
module tb_rv32_icache;

  localparam int LINES      = 64;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = LINE_WORDS * 4;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic [31:0] instr_address_in;
  logic        instr_read_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic        flush_in;
  logic [31:0] mem_address_out;
  logic        mem_read_out;
  logic [31:0] mem_read_value_in;
  logic        mem_ready_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rv32_icache #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_address_in     (instr_address_in),
    .instr_read_in        (instr_read_in),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .flush_in             (flush_in),
    .mem_address_out      (mem_address_out),
    .mem_read_out         (mem_read_out),
    .mem_read_value_in    (mem_read_value_in),
    .mem_ready_in         (mem_ready_in)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  logic [31:0] exp_q[$];   // expected refill beat addresses, in bus order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory image: every word address holds a distinct value (0x100 -> 0xA0).
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a >> 2) + 32'h60;
  endfunction

  // ---------------- memory responder ----------------
  int ready_mode = 0;   // 0: every cycle, 1: every 3rd cycle, 2: random
  int wait_cnt   = 0;
  initial begin
    mem_ready_in      = 1'b0;
    mem_read_value_in = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_read_out) begin
        wait_cnt     = 0;
        mem_ready_in = 1'b0;
      end else begin
        case (ready_mode)
          0:       mem_ready_in = 1'b1;
          1:       begin mem_ready_in = (wait_cnt % 3 == 2); wait_cnt++; end
          default: mem_ready_in = ($urandom_range(0, 2) != 0);
        endcase
      end
      mem_read_value_in = mem_ready_in ? mem_fn(mem_address_out) : $urandom;
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  bit          m_busy  = 1'b0;
  logic [31:0] m_base  = 32'h0;
  int          m_beats = 0;
  bit          m_flush = 1'b0;

  function automatic int unsigned line_idx(input logic [31:0] a);
    return (a / LINE_BYTES) % LINES;
  endfunction

  function automatic int unsigned line_tag(input logic [31:0] a);
    return (a / LINE_BYTES) / LINES;
  endfunction

  // Compare outputs at the falling edge, then advance the model by the inputs
  // the next rising edge will sample.
  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = !m_busy && instr_read_in && !flush_in &&
              m_valid[line_idx(instr_address_in)] &&
              (m_tag[line_idx(instr_address_in)] == line_tag(instr_address_in));
    if (chk_en) begin
      chk("ready", 32'(instr_ready_out), 32'(exp_rdy));
      chk("mem_read", 32'(mem_read_out), 32'(m_busy));
      if (m_busy) chk("mem_addr", mem_address_out, m_base + 32'(4 * m_beats));
      if (exp_rdy) chk("rdata", instr_read_value_out, mem_fn(instr_address_in & ~32'h3));
      if (mem_read_out && mem_ready_in && exp_q.size() > 0)
        chk("beat_addr", mem_address_out, exp_q.pop_front());
    end
    if (reset) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (flush_in) begin
        foreach (m_valid[i]) m_valid[i] = 1'b0;
      end else if (instr_read_in && !exp_rdy) begin
        m_busy  = 1'b1;
        m_base  = instr_address_in & ~32'(LINE_BYTES - 1);
        m_beats = 0;
        m_flush = 1'b0;
      end
    end else begin
      if (flush_in) m_flush = 1'b1;
      if (mem_ready_in) begin
        m_beats++;
        if (m_beats == LINE_WORDS) begin
          m_busy = 1'b0;
          if (m_flush) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
          end else begin
            m_valid[line_idx(m_base)] = 1'b1;
            m_tag[line_idx(m_base)]   = line_tag(m_base);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a fetch from the current cycle and hold it until ready.
  task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] val);
    bit done;
    instr_address_in = a;
    instr_read_in    = 1'b1;
    lat  = 0;
    val  = 32'h0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (instr_ready_out) begin
        val  = instr_read_value_out;
        done = 1'b1;
      end else if (lat >= 200) begin
        total++;
        bad++;
        $display("FAIL fetch_timeout: addr 0x%08h no ready after %0d cycles", a, lat);
        done = 1'b1;
      end else begin
        step();
        lat++;
      end
    end
    step();
    instr_read_in = 1'b0;
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int w = 0; w < LINE_WORDS; w++) exp_q.push_back(base + 32'(4 * w));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    logic [31:0] val;

    foreach (m_valid[i]) begin m_valid[i] = 1'b0; m_tag[i] = 0; end
    reset            = 1'b1;
    instr_read_in    = 1'b0;
    instr_address_in = 32'h0;
    flush_in         = 1'b0;
    repeat (3) step();
    reset  = 1'b0;
    chk_en = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready_out), 32'h0);
    chk("rst_mem_read", 32'(mem_read_out), 32'h0);
    chk("rst_mem_addr", mem_address_out, 32'h0);
    chk("rst_rdata", instr_read_value_out, 32'h0);
    step();

    // 1. cold miss then hits on the rest of the line
    push_line(32'h100);
    fetch(32'h100, lat, val);
    chk("t1_latency", 32'(lat), 32'd5);
    chk("t1_data", val, 32'hA0);
    chk("t1_beats_seen", 32'(exp_q.size()), 32'd0);
    for (int w = 1; w < 4; w++) begin
      fetch(32'h100 + 32'(4 * w), lat, val);
      chk("t1_hit_latency", 32'(lat), 32'd0);
      chk("t1_hit_data", val, 32'hA0 + 32'(w));
    end

    // 2. conflict eviction on index 0x10
    push_line(32'h1100);
    fetch(32'h1100, lat, val);
    chk("t2_latency", 32'(lat), 32'd5);
    chk("t2_data", val, 32'h4A0);
    fetch(32'h100, lat, val);
    chk("t2_reload_latency", 32'(lat), 32'd5);
    chk("t2_reload_data", val, 32'hA0);

    // 3. wait-state refill
    ready_mode = 1;
    push_line(32'h540);
    fetch(32'h540, lat, val);
    chk("t3_latency", 32'(lat), 32'd13);
    chk("t3_data", val, 32'h1B0);
    chk("t3_beats_seen", 32'(exp_q.size()), 32'd0);
    ready_mode = 0;

    // 4. flush in IDLE with a same-cycle read of a cached line
    instr_address_in = 32'h100;
    instr_read_in    = 1'b1;
    flush_in         = 1'b1;
    @(negedge clk);
    chk("t4_flush_no_hit", 32'(instr_ready_out), 32'h0);
    step();
    flush_in = 1'b0;
    fetch(32'h100, lat, val);
    chk("t4_latency", 32'(lat), 32'd5);
    chk("t4_data", val, 32'hA0);

    // 5. flush on beat 1 of a refill: line completes but stays invalid
    push_line(32'h200);
    push_line(32'h200);
    instr_address_in = 32'h200;
    instr_read_in    = 1'b1;
    step();
    step();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    fetch(32'h200, lat, val);
    chk("t5_latency", 32'(lat), 32'd7);
    chk("t5_data", val, 32'hE0);
    chk("t5_beats_seen", 32'(exp_q.size()), 32'd0);

    // 6a. reset on beat 2 of a refill
    instr_address_in = 32'h300;
    instr_read_in    = 1'b1;
    step();
    step();
    step();
    reset         = 1'b1;
    instr_read_in = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6a_mem_read", 32'(mem_read_out), 32'h0);
    chk("t6a_ready", 32'(instr_ready_out), 32'h0);
    step();
    fetch(32'h200, lat, val);
    chk("t6a_invalid_200", 32'(lat), 32'd5);
    fetch(32'h540, lat, val);
    chk("t6a_invalid_540", 32'(lat), 32'd5);

    // 6b. redirect during a refill
    push_line(32'h300);
    push_line(32'h400);
    instr_address_in = 32'h300;
    instr_read_in    = 1'b1;
    step();
    step();
    fetch(32'h400, lat, val);
    chk("t6b_latency", 32'(lat), 32'd8);
    chk("t6b_data", val, 32'h160);
    chk("t6b_beats_seen", 32'(exp_q.size()), 32'd0);

    // randomized run over a small address window to mix hits and conflicts
    ready_mode = 2;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        instr_read_in    = ($urandom_range(0, 3) != 0);
        instr_address_in = 32'($urandom_range(0, 2)) * 32'(LINES * LINE_BYTES) +
                           32'($urandom_range(0, 7)) * 32'(LINE_BYTES) +
                           32'($urandom_range(0, LINE_WORDS - 1)) * 32'd4 +
                           32'($urandom_range(0, 3));
      end
      flush_in = ($urandom_range(0, 39) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      step();
    end
    reset         = 1'b0;
    flush_in      = 1'b0;
    instr_read_in = 1'b0;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
